decade_chain_ctrl: RTL
======================

Name: decade_chain_ctrl

Overview:
Sequencing controller for a chain of DIGITS 4-bit BCD decade counter digits. Each digit has a load / counter_on / counter_up / data_in interface, and counter_on has priority over load inside each digit. The controller presets the chain, generates per-digit carry/borrow enables, pauses and resumes the count, and stops the chain exactly at a target value. It sits between the front-panel/timer logic (start/stop/clear) and the digit bank, and reads back the live digit counts.

Parameters:
DIGITS, 4, number of cascaded decade digits; digit 0 is least significant.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  level; begin a run from IDLE, or resume from PAUSE
stop  in  1  level; pause while RUN
clear  in  1  level; abort and zero the chain
up_mode  in  1  1 = count up to limit, 0 = count down to zero; sampled on start from IDLE
preset  in  4*DIGITS  BCD start value
limit  in  4*DIGITS  BCD terminal value for up mode
digit_count  in  4*DIGITS  live counts read back from the digit bank
dig_load  out  1  load strobe to all digits
dig_data  out  4*DIGITS  load data to the digits
dig_on  out  DIGITS  per-digit count enable
dig_up  out  1  count direction to all digits
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the target is reached
state  out  3  encoded FSM state, for debug

Behaviour:
- Reset (async): state=IDLE, mode_q=0. Outputs: dig_load=0, dig_data=0, dig_on=0, dig_up=0, busy=0, done=0.
- State encoding: IDLE=0, LOAD=1, WAIT=2, RUN=3, PAUSE=4, DONE=5, CLEAR=6.
- IDLE:
  - start=1 -> LOAD.
  - On that edge: mode_q<=up_mode, preset_q<=preset, limit_q<=limit.
- LOAD, one cycle:
  - dig_load=1; dig_data=preset_q, with each nibble >9 clamped to 9.
  - dig_on=0, always.
  - Next state: WAIT.
- WAIT, one cycle: all outputs idle; lets loaded counts settle onto digit_count. Next state: RUN.
- RUN:
  - dig_up=mode_q.
  - dig_on[0]=1.
  - dig_on[i]=1 only if every digit j<i reads 9 (up mode) or 0 (down mode).
  - dig_on is combinational from the registered state, mode_q and digit_count.
- Terminal check in RUN:
  - target = limit_q (nibbles clamped) in up mode, all-zero in down mode.
  - If digit_count == target: dig_on=0 that cycle and next state = DONE. The chain holds exactly at target.
- Priority in RUN: clear > terminal > stop.
  - stop=1 with no terminal -> PAUSE, and dig_on=0 in that cycle.
- PAUSE:
  - dig_on=0; counts held.
  - start=1 -> RUN.
  - stop and start both high -> stay in PAUSE.
- DONE: done=1 for exactly one cycle, then IDLE. Counts are left at target.
- clear=1 in any non-IDLE state -> CLEAR.
  - CLEAR drives dig_load=1, dig_data=0, dig_on=0 for one cycle, then IDLE.
  - clear in IDLE also enters CLEAR.
  - No done pulse on clear.
- Invariant: dig_load and any dig_on bit are never high in the same cycle.
- start while in LOAD, WAIT, RUN, DONE or CLEAR is ignored. preset, limit and up_mode changes mid-run have no effect.
- Preset already equal to target: LOAD -> WAIT -> RUN. The first RUN cycle sees terminal, so no count occurs, and done pulses in the next cycle.
- Up mode with limit < preset: the chain wraps through 9..9 -> 0..0 and continues up to limit.
- Down mode wraps only if the readback is invalid; the controller does not detect this.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Digit contents are not touched.

Test Plan:
- DIGITS=2, down mode, preset=0x12:
  - start pulse -> dig_load high 1 cycle with dig_data=0x12, then WAIT.
  - 12 RUN cycles, with dig_on=2'b11 only on cycles where digit0=0.
  - Count reaches 0x00; done pulses the cycle after RUN sees 00; busy then falls.
- Up mode, preset=0x07, limit=0x25:
  - Carry asserts dig_on[1] exactly at counts 09 and 19.
  - Chain stops at 0x25; dig_on=0 on the terminal cycle; done pulses once.
- Pause and resume:
  - stop high for 5 cycles mid-run -> dig_on=0 and digit_count frozen.
  - start -> counting resumes from the same value.
  - Total RUN-count cycles are unchanged.
- clear during RUN at count 0x34:
  - Next cycle: CLEAR with dig_load=1 and dig_data=0x00.
  - Then IDLE; done is never asserted.
- preset=0xF3 (invalid high nibble), down mode -> dig_data=0x93 and the run completes normally. preset=0x00 in down mode -> done 3 cycles after start with no dig_on activity.
- Async reset asserted mid-RUN, between clock edges -> state=0 and all outputs 0 immediately. A new start after reset release runs normally.

Source files
------------

// File: rtl/decade_chain_ctrl_if.sv
// decade_chain_ctrl_if
//   Bundles the front-panel controls, the digit-bank drive lines and the
//   status outputs of the decade chain controller.
//   master : the controller (consumes controls and readback, drives digits/status)
//   slave  : the surrounding logic (drives controls and readback)
//   Signals:
//     start, stop, clear, up_mode : run controls (levels)
//     preset, limit               : BCD start value / up-mode terminal value
//     digit_count                 : live BCD counts read back from the digit bank
//     dig_load, dig_data          : load strobe and load data to all digits
//     dig_on, dig_up              : per-digit count enable, shared direction
//     busy, done, state           : status (done is a one-cycle pulse)
interface decade_chain_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  stop;
   logic                  clear;
   logic                  up_mode;
   logic [4*DIGITS-1:0]   preset;
   logic [4*DIGITS-1:0]   limit;
   logic [4*DIGITS-1:0]   digit_count;
   logic                  dig_load;
   logic [4*DIGITS-1:0]   dig_data;
   logic [DIGITS-1:0]     dig_on;
   logic                  dig_up;
   logic                  busy;
   logic                  done;
   logic [2:0]            state;

   modport master (
      input  start, stop, clear, up_mode, preset, limit, digit_count,
      output dig_load, dig_data, dig_on, dig_up, busy, done, state
   );

   modport slave (
      output start, stop, clear, up_mode, preset, limit, digit_count,
      input  dig_load, dig_data, dig_on, dig_up, busy, done, state
   );
endinterface

// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl
//   Sequences a chain of DIGITS cascaded BCD decade counters: presets the
//   chain, generates ripple carry/borrow enables, pauses/resumes, and stops
//   the chain exactly on its target value.
//   Ports:
//     clock : system clock, rising edge
//     reset : asynchronous, active-high
//     bus   : decade_chain_ctrl_if.master (controls, digit drive, status)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; nothing driven
//   LOAD   | one cycle: load clamped preset into all digits
//   WAIT   | one cycle: let loaded counts appear on the readback
//   RUN    | counting; digit 0 always enabled, higher digits on carry/borrow
//   PAUSE  | counts held until start (without stop)
//   DONE   | one-cycle done pulse, chain held at target
//   CLEAR  | one cycle: load zero into all digits, no done pulse
module decade_chain_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic               clock,
   input  logic               reset,
   decade_chain_ctrl_if.master bus
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RUN   = 3'd3,
      ST_PAUSE = 3'd4,
      ST_DONE  = 3'd5,
      ST_CLEAR = 3'd6
   } state_t;

   // Any nibble above 9 is not a BCD digit; saturate it to 9.
   function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   state_t         state_q, state_d;
   logic           mode_q;
   logic [W-1:0]   limit_q;
   logic           dig_load_q;
   logic [W-1:0]   dig_data_q;
   logic           dig_up_q;
   logic           busy_q;
   logic           done_q;

   logic [W-1:0]   target;
   logic           terminal;
   logic           run_en;
   logic [DIGITS-1:0] dig_on_d;

   assign target   = mode_q ? limit_q : '0;
   assign terminal = (bus.digit_count == target);

   // Counting is suppressed on the cycle that leaves RUN so the chain never
   // steps past target, into a pause, or while being cleared.
   assign run_en = (state_q == ST_RUN) && !bus.clear && !terminal && !bus.stop;

   // Ripple enable: digit i counts only when every lower digit sits at the
   // wrap value (9 counting up, 0 counting down).
   always_comb begin
      logic ripple;
      dig_on_d = '0;
      ripple   = run_en;
      for (int i = 0; i < DIGITS; i++) begin
         dig_on_d[i] = ripple;
         ripple      = ripple && (bus.digit_count[4*i +: 4] == (mode_q ? 4'd9 : 4'd0));
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = ST_CLEAR;
      end else begin
         unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_RUN;
            ST_RUN: begin
               if (terminal)      state_d = ST_DONE;
               else if (bus.stop) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (bus.start && !bus.stop) state_d = ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         limit_q    <= '0;
         dig_load_q <= 1'b0;
         dig_data_q <= '0;
         dig_up_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            mode_q  <= bus.up_mode;
            limit_q <= clamp_bcd(bus.limit);
         end
         // LOAD is only reachable from IDLE, so the live preset on this edge
         // is the value captured for the run.
         dig_load_q <= (state_d == ST_LOAD) || (state_d == ST_CLEAR);
         dig_data_q <= (state_d == ST_LOAD) ? clamp_bcd(bus.preset) : '0;
         // mode_q is already valid whenever RUN is entered (from WAIT/PAUSE).
         dig_up_q   <= (state_d == ST_RUN) && mode_q;
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign bus.dig_load = dig_load_q;
   assign bus.dig_data = dig_data_q;
   assign bus.dig_on   = dig_on_d;
   assign bus.dig_up   = dig_up_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.state    = state_q;

endmodule
